// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD counter family: digit width, the largest
// legal digit value and the digit type, plus the terminal-digit test used by
// every digit slice.
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    // A digit is terminal once it has reached 9. Values 10..15 can only appear
    // through a load and are deliberately lumped in with 9, so that they roll
    // over to 0 on their next advance instead of counting up through garbage.
    function automatic logic is_terminal(input bcd_digit_t value);
        return value >= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD digit slice of the up counter: the digit register, its terminal
// detect and the carry out to the next more significant digit.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset, clears q
//   ei     in   carry in: this digit advances on the edge when ei=1
//   ld     in   synchronous load of d, overrides ei
//   d      in   digit load value
//   sat    in   1 = a terminal digit holds instead of wrapping to 0
//   eu     out  carry out, high when this digit and all below it roll over
//   q      out  current digit value
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       ei,
    input  logic       ld,
    input  bcd_digit_t d,
    input  logic       sat,
    output logic       eu,
    output bcd_digit_t q
);

    logic       terminal;
    bcd_digit_t q_next;

    assign terminal = is_terminal(q);

    // The carry is blocked by a load so that a load cycle never looks like a
    // roll-over to the stages above, and by reset so that nothing downstream
    // counts while the chain is being cleared.
    assign eu = ei & ~ld & terminal & ~reset;

    // Next digit value: load first, then advance, otherwise hold. The top
    // level only raises sat when the whole counter is at its ceiling, so a
    // terminal digit below a non-terminal one still wraps normally.
    always_comb begin
        q_next = q;
        if (ld) begin
            q_next = d;
        end else if (ei) begin
            if (terminal) begin
                q_next = sat ? q : '0;
            end else begin
                q_next = q + 4'd1;
            end
        end
    end

    // Digit register, cleared immediately by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/bcd_up_counter.sv
// -----------------------------------------------------------------------------
// bcd_up_counter
// N-digit synchronous BCD up counter with enable-in / carry-out chaining.
// Instances cascade by wiring eu of one stage to ei of the next.
//
// Build option:
//   BCD_UP_COUNTER_SAT_EN  defined   -> saturates at all-9 (eu still pulses)
//                          undefined -> wraps from all-9 to all-0
//
// Parameters:
//   DIGITS  number of BCD digits (1..8)
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset, q=0 at once
//   ei     in   count enable / carry in
//   ld     in   synchronous parallel load of d, priority over ei
//   d      in   load value, digit 0 in bits [3:0]
//   eu     out  combinational carry out, feeds the next stage's ei
//   q      out  current count, digit 0 in bits [3:0]
// -----------------------------------------------------------------------------
module bcd_up_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ei,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   d,
    output logic                  eu,
    output logic [4*DIGITS-1:0]   q
);

    logic sat;

    // Each digit gets its carry in from the digit below; digit 0 takes the
    // external enable. The carry wires live in their own generate scopes so
    // the ripple is a chain of separate nets rather than one self-dependent
    // vector.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic       ei_w;
        logic       eu_w;
        bcd_digit_t q_w;

        if (i == 0) begin : g_first
            assign ei_w = ei;
        end else begin : g_next
            assign ei_w = g_digit[i-1].eu_w;
        end

        bcd_digit u_digit (
            .clock (clock),
            .reset (reset),
            .ei    (ei_w),
            .ld    (ld),
            .d     (d[DIGIT_W*i +: DIGIT_W]),
            .sat   (sat),
            .eu    (eu_w),
            .q     (q_w)
        );

        assign q[DIGIT_W*i +: DIGIT_W] = q_w;
    end

    assign eu = g_digit[DIGITS-1].eu_w;

    // In the saturating build the final carry doubles as the hold request:
    // it is high exactly when an increment would take the counter past
    // all-9, which is the only case where the digits must stay put.
`ifdef BCD_UP_COUNTER_SAT_EN
    assign sat = eu;
`else
    assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_up_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_up_counter
// Self-checking bench for bcd_up_counter with DIGITS=2. A behavioural model
// of the digit rules tracks the expected count; inputs change on the falling
// edge and outputs are compared shortly after it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_up_counter;

`ifdef BCD_UP_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       ei;
    logic       ld;
    logic [7:0] d;
    logic       eu;
    logic [7:0] q;

    logic       c_reset;
    logic       c_ei;
    logic       c_ld;
    logic [7:0] c_d;
    logic       lo_eu;
    logic       hi_eu;
    logic [7:0] lo_q;
    logic [7:0] hi_q;

    int checks;
    int errors;

    logic [7:0] mq;

    bcd_up_counter #(.DIGITS(2)) dut (
        .clock (clock), .reset (reset), .ei (ei), .ld (ld),
        .d (d), .eu (eu), .q (q)
    );

    bcd_up_counter #(.DIGITS(2)) dut_lo (
        .clock (clock), .reset (c_reset), .ei (c_ei), .ld (c_ld),
        .d (c_d), .eu (lo_eu), .q (lo_q)
    );

    bcd_up_counter #(.DIGITS(2)) dut_hi (
        .clock (clock), .reset (c_reset), .ei (lo_eu), .ld (c_ld),
        .d (c_d), .eu (hi_eu), .q (hi_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference rules: a digit is terminal at >= 9; the increment is a
    // ripple-carry addition of one where a terminal digit becomes 0.
    function automatic logic all_term(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[3:0];
        hi = v[7:4];
        return (lo >= 4'd9) && (hi >= 4'd9);
    endfunction

    function automatic logic [7:0] model_next(input logic [7:0] cur, input logic e,
                                              input logic l, input logic [7:0] dv);
        logic [7:0] res;
        logic [3:0] dig;
        if (l) return dv;
        if (!e) return cur;
        if (SAT && all_term(cur)) return cur;
        res = cur;
        for (int i = 0; i < 2; i++) begin
            dig = res[4*i +: 4];
            if (dig >= 4'd9) begin
                res[4*i +: 4] = 4'd0;
            end else begin
                res[4*i +: 4] = dig + 4'd1;
                break;
            end
        end
        return res;
    endfunction

    function automatic logic model_eu(input logic [7:0] cur, input logic e,
                                      input logic l, input logic r);
        return e && !l && !r && all_term(cur);
    endfunction

    function automatic logic [7:0] to_bcd(input int k);
        logic [7:0] v;
        v[7:4] = 4'((k / 10) % 10);
        v[3:0] = 4'(k % 10);
        return v;
    endfunction

    // Advance one clock edge and update the model with the sampled inputs.
    task automatic cycle();
        @(posedge clock);
        if (reset) mq = 8'h00;
        else       mq = model_next(mq, ei, ld, d);
        @(negedge clock);
    endtask

    task automatic load(input logic [7:0] v);
        ld = 1'b1; ei = 1'b0; d = v;
        cycle();
        ld = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ei = 1'b1; ld = 1'b0; d = 8'h00;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (q !== 8'h00 || eu !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_state q=%h eu=%b required q=00 eu=0", q, eu);
            end
            cycle();
        end
        mq = 8'h00;
    endtask

    task automatic test_count();
        reset = 1'b0; ei = 1'b1; ld = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++;
            if (q !== to_bcd(k) || q !== mq || eu !== 1'b0) begin
                errors++;
                $display("[TB] FAIL count_%0d q=%h eu=%b required q=%h eu=0", k, q, eu, to_bcd(k));
            end
            cycle();
        end
        #1;
        checks++;
        if (q !== 8'h12) begin
            errors++;
            $display("[TB] FAIL count_end q=%h required 12", q);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q [4];
        logic       exp_eu [3];
`ifdef BCD_UP_COUNTER_SAT_EN
        exp_q  = '{8'h98, 8'h99, 8'h99, 8'h99};
        exp_eu = '{1'b0, 1'b1, 1'b1};
`else
        exp_q  = '{8'h98, 8'h99, 8'h00, 8'h01};
        exp_eu = '{1'b0, 1'b1, 1'b0};
`endif
        load(8'h98);
        ei = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (q !== exp_q[i] || q !== mq || eu !== exp_eu[i]) begin
                errors++;
                $display("[TB] FAIL wrap_%0d q=%h eu=%b required q=%h eu=%b", i, q, eu, exp_q[i], exp_eu[i]);
            end
            cycle();
        end
        #1;
        checks++;
        if (q !== exp_q[3] || q !== mq) begin
            errors++;
            $display("[TB] FAIL wrap_end q=%h required %h", q, exp_q[3]);
        end
    endtask

    task automatic test_load_priority();
        load(8'h45);
        ld = 1'b1; ei = 1'b1; d = 8'h99;
        #1;
        checks++;
        if (eu !== 1'b0 || q !== 8'h45) begin
            errors++;
            $display("[TB] FAIL load_prio_eu q=%h eu=%b required q=45 eu=0", q, eu);
        end
        cycle();
        ld = 1'b0; ei = 1'b0;
        #1;
        checks++;
        if (q !== 8'h99 || q !== mq) begin
            errors++;
            $display("[TB] FAIL load_prio_q q=%h required 99", q);
        end
        // Load while already terminal with ei high must still block eu.
        ld = 1'b1; ei = 1'b1; d = 8'h20;
        #1;
        checks++;
        if (eu !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_prio_terminal eu=%b required 0", eu);
        end
        cycle();
        ld = 1'b0; ei = 1'b0;
    endtask

    task automatic test_hold();
        load(8'h37);
        ei = 1'b0; d = 8'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (q !== 8'h37 || eu !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_37_%0d q=%h eu=%b required q=37 eu=0", i, q, eu);
            end
            cycle();
        end
        load(8'h99);
        ei = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (q !== 8'h99 || eu !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_99_%0d q=%h eu=%b required q=99 eu=0", i, q, eu);
            end
            cycle();
        end
    endtask

    task automatic test_async_reset();
        load(8'h56);
        ei = 1'b1;
        #3;
        reset = 1'b1;
        mq = 8'h00;
        #1;
        checks++;
        if (q !== 8'h00 || eu !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset q=%h eu=%b required q=00 eu=0", q, eu);
        end
        cycle();
        reset = 1'b0; ei = 1'b1;
        #1;
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_reset_hold q=%h required 00", q);
        end
        cycle();
        #1;
        checks++;
        if (q !== 8'h01 || q !== mq) begin
            errors++;
            $display("[TB] FAIL async_reset_resume q=%h required 01", q);
        end
    endtask

    task automatic test_invalid_digit();
        load(8'h0C);
        ei = 1'b1;
        #1;
        checks++;
        if (eu !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invalid_eu eu=%b required 0", eu);
        end
        cycle();
        ei = 1'b0;
        #1;
        checks++;
        if (q !== 8'h10 || q !== mq) begin
            errors++;
            $display("[TB] FAIL invalid_wrap q=%h required 10", q);
        end
    endtask

    task automatic test_random();
        logic exp_eu;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            ld    = ($urandom_range(0, 7) == 0);
            ei    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) d = 8'($urandom);
            else d = {4'($urandom_range(7, 9)), 4'($urandom_range(0, 9))};
            if (reset) mq = 8'h00;
            exp_eu = model_eu(mq, ei, ld, reset);
            #1;
            checks++;
            if (q !== mq || eu !== exp_eu) begin
                errors++;
                $display("[TB] FAIL random_%0d q=%h eu=%b required q=%h eu=%b (ei=%b ld=%b rst=%b)",
                         n, q, eu, mq, exp_eu, ei, ld, reset);
            end
            cycle();
        end
        reset = 1'b0; ld = 1'b0; ei = 1'b0;
    endtask

    task automatic test_cascade();
        logic [7:0] lo_m;
        logic [7:0] hi_m;
        logic       lo_eu_m;
        lo_m = 8'h00; hi_m = 8'h00;
        c_reset = 1'b0; c_ei = 1'b1; c_ld = 1'b0; c_d = 8'h00;
        for (int n = 0; n < 100; n++) begin
            #1;
            lo_eu_m = model_eu(lo_m, c_ei, c_ld, 1'b0);
            if (n == 99) begin
                checks++;
                if (lo_eu !== lo_eu_m || lo_q !== lo_m) begin
                    errors++;
                    $display("[TB] FAIL cascade_carry lo_eu=%b lo_q=%h required %b %h", lo_eu, lo_q, lo_eu_m, lo_m);
                end
            end
            @(posedge clock);
            hi_m = model_next(hi_m, lo_eu_m, c_ld, c_d);
            lo_m = model_next(lo_m, c_ei, c_ld, c_d);
            @(negedge clock);
        end
        c_ei = 1'b0;
        #1;
        checks++;
        if (hi_q !== hi_m || lo_q !== lo_m || hi_q !== 8'h01) begin
            errors++;
            $display("[TB] FAIL cascade_100 hi=%h lo=%h required hi=%h lo=%h", hi_q, lo_q, hi_m, lo_m);
        end
    endtask

    initial begin
        checks = 0; errors = 0; mq = 8'h00;
        reset = 1'b1; ei = 1'b0; ld = 1'b0; d = 8'h00;
        c_reset = 1'b1; c_ei = 1'b0; c_ld = 1'b0; c_d = 8'h00;
        @(negedge clock);
        test_reset();
        test_count();
        test_wrap();
        test_load_priority();
        test_hold();
        test_async_reset();
        test_invalid_digit();
        test_random();
        test_cascade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
